mix_add_round: RTL and testbench

MIX_ADD_ROUND -- requirements
Module: mix_add_round

---
 rtl/mix_add_round_pkg.sv | 19 +
 rtl/mix_add_round_mixcol.sv | 25 ++
 rtl/mix_add_round.sv | 99 +++++++++
 tb/tb_mix_add_round.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mix_add_round_pkg.sv
// Shared types and GF(2^8) helpers for the MixColumns + AddRoundKey round block.
package mix_add_round_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_e;

  // Index 0 is the most significant word, so column c maps straight to element c.
  typedef logic [0:3][31:0] aes_state_t;

  localparam logic [7:0] GF_POLY = 8'h1B;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/mix_add_round_mixcol.sv
// Single-column MixColumns, purely combinational; row 0 byte sits in the column MSB.
module mix_add_round_mixcol
  import mix_add_round_pkg::*;
(
  input  logic [31:0] i_col,
  output logic [31:0] o_col
);

  logic [7:0] w_b0, w_b1, w_b2, w_b3;
  logic [7:0] w_x0, w_x1, w_x2, w_x3;

  assign {w_b0, w_b1, w_b2, w_b3} = i_col;

  assign w_x0 = xtime(w_b0);
  assign w_x1 = xtime(w_b1);
  assign w_x2 = xtime(w_b2);
  assign w_x3 = xtime(w_b3);

  // 03*b is xtime(b)^b
  assign o_col[31:24] = w_x0 ^ (w_x1 ^ w_b1) ^ w_b2 ^ w_b3;
  assign o_col[23:16] = w_b0 ^ w_x1 ^ (w_x2 ^ w_b2) ^ w_b3;
  assign o_col[15:8]  = w_b0 ^ w_b1 ^ w_x2 ^ (w_x3 ^ w_b3);
  assign o_col[7:0]   = (w_x0 ^ w_b0) ^ w_b1 ^ w_b2 ^ w_x3;

endmodule

// File: rtl/mix_add_round.sv
// AES round tail: MixColumns (skipped on the last round) then AddRoundKey,
// COLS_PER_CYCLE columns per BUSY cycle, one block in flight, held in DONE until taken.
module mix_add_round
  import mix_add_round_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic [127:0] in_key,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mix_add_round: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

  fsm_e       r_fsm;
  fsm_e       w_fsm_nxt;
  logic [1:0] r_cnt;
  aes_state_t r_state;
  aes_state_t r_key;
  aes_state_t r_result;
  logic       r_last;

  logic [1:0]  w_idx [COLS_PER_CYCLE];
  logic [31:0] w_mix [COLS_PER_CYCLE];
  logic [31:0] w_res [COLS_PER_CYCLE];

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    // Counter is always a multiple of the step, so this never wraps past column 3.
    assign w_idx[g] = r_cnt + 2'(g);

    mix_add_round_mixcol u_mixcol (
      .i_col (r_state[w_idx[g]]),
      .o_col (w_mix[g])
    );

    assign w_res[g] = (r_last ? r_state[w_idx[g]] : w_mix[g]) ^ r_key[w_idx[g]];
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      IDLE:    if (in_valid)           w_fsm_nxt = BUSY;
      BUSY:    if (r_cnt == LAST_CNT)  w_fsm_nxt = DONE;
      DONE:    if (out_ready)          w_fsm_nxt = IDLE;
      default:                         w_fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_fsm <= IDLE;
    else        r_fsm <= w_fsm_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_last   <= 1'b0;
      r_state  <= '0;
      r_key    <= '0;
      r_result <= '0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (in_valid) begin
            r_state <= in_state;
            r_key   <= in_key;
            r_last  <= in_last;
            r_cnt   <= '0;
          end
        end
        BUSY: begin
          for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            r_result[w_idx[g]] <= w_res[g];
          end
          r_cnt <= r_cnt + STEP;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode registered state only; no combinational path from the handshake inputs.
  assign in_ready  = (r_fsm == IDLE);
  assign out_valid = (r_fsm == DONE);
  assign out_state = r_result;

endmodule

// File: tb/tb_mix_add_round.sv
// Directed bench for mix_add_round: three instances (1, 2, 4 columns per cycle) share stimulus.
module tb_mix_add_round;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_last;
  logic         out_ready;
  logic [127:0] in_state;
  logic [127:0] in_key;

  logic         ir [3];
  logic         ov [3];
  logic [127:0] os [3];

  int n_vec = 0;
  int n_mis = 0;
  int lat [3] = '{5, 3, 2};

  logic [127:0] sb0 [$];
  logic [127:0] sb1 [$];
  logic [127:0] sb2 [$];

  localparam logic [127:0] V_ST  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V_E0  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V_EFF = 128'h71b25e43_6023a762_fefefefe_39393939;
  localparam logic [127:0] ONES  = {128{1'b1}};

  always #5 clk = ~clk;

  mix_add_round #(.COLS_PER_CYCLE(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
    .in_state(in_state), .in_key(in_key), .in_last(in_last),
    .out_valid(ov[0]), .out_ready(out_ready), .out_state(os[0]));

  mix_add_round #(.COLS_PER_CYCLE(2)) u_c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
    .in_state(in_state), .in_key(in_key), .in_last(in_last),
    .out_valid(ov[1]), .out_ready(out_ready), .out_state(os[1]));

  mix_add_round #(.COLS_PER_CYCLE(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
    .in_state(in_state), .in_key(in_key), .in_last(in_last),
    .out_valid(ov[2]), .out_ready(out_ready), .out_state(os[2]));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m2(input logic [7:0] b);
    logic [7:0] s;
    s = {b[6:0], 1'b0};
    return b[7] ? (s ^ 8'h1b) : s;
  endfunction

  function automatic logic [31:0] mc(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {m2(a0) ^ m2(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ m2(a1) ^ m2(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ m2(a2) ^ m2(a3) ^ a3,
            m2(a0) ^ a0 ^ a1 ^ a2 ^ m2(a3)};
  endfunction

  function automatic logic [127:0] ref_out(input logic [127:0] s, input logic [127:0] k, input logic l);
    logic [127:0] r;
    logic [31:0]  col;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      col = s[127-32*c -: 32];
      r[127-32*c -: 32] = (l ? col : mc(col)) ^ k[127-32*c -: 32];
    end
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic pop_exp(input int d, output logic [127:0] e, output bit ok);
    ok = 1'b1;
    e  = '0;
    case (d)
      0: if (sb0.size() > 0) e = sb0.pop_front(); else ok = 1'b0;
      1: if (sb1.size() > 0) e = sb1.pop_front(); else ok = 1'b0;
      default: if (sb2.size() > 0) e = sb2.pop_front(); else ok = 1'b0;
    endcase
  endtask

  // Called at a negedge; offers one block and returns just after the accepting edge.
  task automatic send(input logic [127:0] s, input logic [127:0] k, input logic l,
                      input logic [127:0] exp, input bit track);
    for (int d = 0; d < 3; d++) check($sformatf("in_ready_before_send[%0d]", d), 128'(ir[d]), 128'(1));
    in_state = s;
    in_key   = k;
    in_last  = l;
    in_valid = 1'b1;
    if (track) begin
      sb0.push_back(exp);
      sb1.push_back(exp);
      sb2.push_back(exp);
    end
    @(posedge clk);
  endtask

  // Watches all instances for their result; k counts cycles after the accepting edge.
  task automatic collect(input bit wait_idle, output logic [127:0] last_exp);
    bit seen [3];
    bit ok;
    bit done;
    logic [127:0] e;
    last_exp = '0;
    for (int d = 0; d < 3; d++) seen[d] = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k == 1) begin
        in_valid = 1'b0;
        in_state = rnd128();
        in_key   = rnd128();
        in_last  = 1'($urandom);
      end
      for (int d = 0; d < 3; d++) begin
        if (ov[d] && !seen[d]) begin
          seen[d] = 1'b1;
          check($sformatf("latency[%0d]", d), 128'(k), 128'(lat[d]));
          check($sformatf("no_ready_with_valid[%0d]", d), 128'(ir[d]), 128'(0));
          pop_exp(d, e, ok);
          check($sformatf("scoreboard_nonempty[%0d]", d), 128'(ok), 128'(1));
          check($sformatf("out_state[%0d]", d), os[d], e);
          if (d == 0) last_exp = e;
        end
      end
      done = seen[0] && seen[1] && seen[2];
      if (wait_idle) done = done && ir[0] && ir[1] && ir[2];
      if (done) break;
    end
    for (int d = 0; d < 3; d++) check($sformatf("result_seen[%0d]", d), 128'(seen[d]), 128'(1));
  endtask

  initial begin
    logic [127:0] s, k, e, held;
    logic         l;
    logic         any_vld;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_state  = '0;
    in_key    = '0;
    out_ready = 1'b1;

    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_in_ready[%0d]", d), 128'(ir[d]), 128'(1));
      check($sformatf("rst_out_valid[%0d]", d), 128'(ov[d]), 128'(0));
      check($sformatf("rst_out_state[%0d]", d), os[d], '0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    send(V_ST, '0, 1'b0, V_E0, 1'b1);
    collect(1'b1, e);
    send(V_ST, ONES, 1'b0, V_EFF, 1'b1);
    collect(1'b1, e);
    send(V_ST, '0, 1'b1, V_ST, 1'b1);
    collect(1'b1, e);

    for (int i = 0; i < 3; i++) begin
      s = rnd128();
      k = rnd128();
      l = (i == 2);
      send(s, k, l, ref_out(s, k, l), 1'b1);
      collect(1'b1, e);
    end

    // Backpressure: hold DONE while upstream keeps offering garbage.
    out_ready = 1'b0;
    k = rnd128();
    send(V_ST, k, 1'b0, V_E0 ^ k, 1'b1);
    collect(1'b0, held);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'(i % 2);
      in_state = rnd128();
      in_key   = rnd128();
      in_last  = 1'($urandom);
      for (int d = 0; d < 3; d++) begin
        check($sformatf("bp_out_valid[%0d]", d), 128'(ov[d]), 128'(1));
        check($sformatf("bp_in_ready[%0d]", d), 128'(ir[d]), 128'(0));
      end
      check("bp_out_state", os[0], held);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int d = 0; d < 3; d++) check($sformatf("handshake_no_overlap[%0d]", d), 128'(ir[d]), 128'(0));
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("post_hs_in_ready[%0d]", d), 128'(ir[d]), 128'(1));
      check($sformatf("post_hs_out_valid[%0d]", d), 128'(ov[d]), 128'(0));
    end

    // Reset during the second BUSY cycle aborts the block.
    send(V_ST, ONES, 1'b0, V_EFF, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("abort_in_ready[%0d]", d), 128'(ir[d]), 128'(1));
      check($sformatf("abort_out_valid[%0d]", d), 128'(ov[d]), 128'(0));
      check($sformatf("abort_out_state[%0d]", d), os[d], '0);
    end
    any_vld = 1'b0;
    repeat (6) begin
      @(negedge clk);
      any_vld = any_vld | ov[0] | ov[1] | ov[2];
    end
    check("abort_no_out_valid", 128'(any_vld), 128'(0));

    send(V_ST, '0, 1'b0, V_E0, 1'b1);
    collect(1'b1, e);

    check("scoreboard_drained", 128'(sb0.size() + sb1.size() + sb2.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
